// File: rtl/eth_parser_pkg.sv
// Shared L2 parsing types and constants: ethertype type, TPID values, header lengths.
package eth_parser_pkg;

    typedef logic [15:0] ethertype_t;

    localparam ethertype_t ETHERTYPE_VLAN = 16'h8100;
    localparam ethertype_t ETHERTYPE_QINQ = 16'h88A8;

    localparam logic [4:0] L2_HEADER_NO_VLAN = 5'd14;
    localparam logic [4:0] L2_HEADER_VLAN    = 5'd18;

    // Each resolved tag adds 4 bytes to the untagged 14-byte header.
    function automatic logic [4:0] l2_len(input logic [2:0] tags);
        return L2_HEADER_NO_VLAN + {tags, 2'b00};
    endfunction

endpackage

// File: rtl/vlan_tpid_match.sv
// Combinational TPID classifier; the 802.1ad TPID counts as a tag only when
// VLAN_QINQ_EN is defined.
module vlan_tpid_match
    import eth_parser_pkg::*;
#(
    parameter ethertype_t TPID_8021Q  = ETHERTYPE_VLAN,
    parameter ethertype_t TPID_8021AD = ETHERTYPE_QINQ
) (
    input  ethertype_t value,
    output logic       is_tpid
);

`ifdef VLAN_QINQ_EN
    localparam bit QINQ_EN = 1'b1;
`else
    localparam bit QINQ_EN = 1'b0;
`endif

    assign is_tpid = (value == TPID_8021Q) || (QINQ_EN && (value == TPID_8021AD));

endmodule

// File: rtl/vlan_tag_walker.sv
// Walks stacked VLAN tags of a byte-serial Ethernet frame and publishes the
// resolved ethertype, tag VIDs and header length. QinQ TPID gated by VLAN_QINQ_EN.
module vlan_tag_walker
    import eth_parser_pkg::*;
#(
    parameter int         MAX_TAGS    = 2,
    parameter ethertype_t TPID_8021Q  = ETHERTYPE_VLAN,
    parameter ethertype_t TPID_8021AD = ETHERTYPE_QINQ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  vlan_count,
    output logic [11:0] outer_vid,
    output logic [11:0] inner_vid,
    output ethertype_t  resolved_ethertype,
    output logic [4:0]  l2_header_len,
    output logic        tag_overflow,
    output logic        runt
);

    typedef enum logic [2:0] {IDLE, MAC, ETYPE, TCI, DRAIN} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_TAGS);

    state_t      state;
    logic [4:0]  cnt;
    logic [7:0]  hi_byte;
    logic [3:0]  tci_nib;
    logic [2:0]  w_count, nxt_count;
    logic [11:0] w_outer, w_inner, nxt_outer, nxt_inner;
    logic        accept, is_tpid, take_tag;
    logic        pub, pub_runt, pub_ovf;
    ethertype_t  pub_etype, etype_val;

    assign in_ready  = !res_valid || res_ready;
    assign accept    = in_valid && in_ready;
    assign etype_val = {hi_byte, in_data};
    assign take_tag  = is_tpid && (w_count < MAX_CNT);

    vlan_tpid_match #(
        .TPID_8021Q (TPID_8021Q),
        .TPID_8021AD(TPID_8021AD)
    ) u_match (
        .value  (etype_val),
        .is_tpid(is_tpid)
    );

    // Working fields after this beat, plus whether this beat publishes a result.
    always_comb begin
        nxt_count = w_count;
        nxt_outer = w_outer;
        nxt_inner = w_inner;
        pub       = 1'b0;
        pub_runt  = 1'b0;
        pub_ovf   = 1'b0;
        pub_etype = '0;
        if (accept) begin
            if (in_sop) begin
                nxt_count = '0;
                nxt_outer = '0;
                nxt_inner = '0;
                pub       = in_eop;
                pub_runt  = in_eop;
            end else begin
                case (state)
                    MAC: begin
                        pub      = in_eop;
                        pub_runt = in_eop;
                    end
                    ETYPE: begin
                        if (cnt[0] && !take_tag) begin
                            pub       = 1'b1;
                            pub_ovf   = is_tpid;
                            pub_etype = etype_val;
                        end else begin
                            pub      = in_eop;
                            pub_runt = in_eop;
                        end
                    end
                    TCI: begin
                        if (cnt[0]) begin
                            if (w_count == 3'd0) nxt_outer = {tci_nib, in_data};
                            else if (w_count == 3'd1) nxt_inner = {tci_nib, in_data};
                            nxt_count = w_count + 3'd1;
                        end
                        pub      = in_eop;
                        pub_runt = in_eop;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            hi_byte            <= '0;
            tci_nib            <= '0;
            w_count            <= '0;
            w_outer            <= '0;
            w_inner            <= '0;
            res_valid          <= 1'b0;
            vlan_count         <= '0;
            outer_vid          <= '0;
            inner_vid          <= '0;
            resolved_ethertype <= '0;
            l2_header_len      <= L2_HEADER_NO_VLAN;
            tag_overflow       <= 1'b0;
            runt               <= 1'b0;
        end else begin
            w_count <= nxt_count;
            w_outer <= nxt_outer;
            w_inner <= nxt_inner;

            // A publish only happens on an accepted beat, so a stalled result is never overwritten.
            if (pub) begin
                res_valid          <= 1'b1;
                vlan_count         <= nxt_count;
                outer_vid          <= nxt_outer;
                inner_vid          <= nxt_inner;
                resolved_ethertype <= pub_etype;
                l2_header_len      <= l2_len(nxt_count);
                tag_overflow       <= pub_ovf;
                runt               <= pub_runt;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            if (accept) begin
                if (in_sop) begin
                    cnt   <= 5'd1;
                    state <= in_eop ? IDLE : MAC;
                end else begin
                    case (state)
                        MAC: begin
                            cnt <= cnt + 5'd1;
                            if (in_eop)            state <= IDLE;
                            else if (cnt == 5'd11) state <= ETYPE;
                        end
                        ETYPE: begin
                            cnt <= cnt + 5'd1;
                            if (!cnt[0]) hi_byte <= in_data;
                            if (in_eop)      state <= IDLE;
                            else if (cnt[0]) state <= take_tag ? TCI : DRAIN;
                        end
                        TCI: begin
                            cnt <= cnt + 5'd1;
                            if (!cnt[0]) tci_nib <= in_data[3:0];
                            if (in_eop)      state <= IDLE;
                            else if (cnt[0]) state <= ETYPE;
                        end
                        DRAIN: if (in_eop) state <= IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vlan_tag_walker.sv
// Directed bench for vlan_tag_walker: default instance plus a MAX_TAGS=1 instance.
module tb_vlan_tag_walker;
    import eth_parser_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_data = '0;
    logic in_sop = 1'b0, in_eop = 1'b0, v0 = 1'b0, v1 = 1'b0, rr0 = 1'b1, rr1 = 1'b1;
    logic rdy0, rv0, ovf0, runt0, rdy1, rv1, ovf1, runt1;
    logic [2:0] cnt0, cnt1;
    logic [11:0] ov0, iv0, ov1, iv1;
    ethertype_t et0, et1;
    logic [4:0] len0, len1;

    vlan_tag_walker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .res_valid(rv0), .res_ready(rr0),
        .vlan_count(cnt0), .outer_vid(ov0), .inner_vid(iv0), .resolved_ethertype(et0),
        .l2_header_len(len0), .tag_overflow(ovf0), .runt(runt0)
    );

    vlan_tag_walker #(.MAX_TAGS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .res_valid(rv1), .res_ready(rr1),
        .vlan_count(cnt1), .outer_vid(ov1), .inner_vid(iv1), .resolved_ethertype(et1),
        .l2_header_len(len1), .tag_overflow(ovf1), .runt(runt1)
    );

    typedef struct packed {
        logic [2:0]  cnt;
        logic [11:0] o;
        logic [11:0] i;
        logic [15:0] et;
        logic [4:0]  len;
        logic        ovf;
        logic        runt;
    } res_t;

    res_t q0[$], q1[$];
    logic [7:0] fb[$];
    int n_cmp = 0, n_err = 0;

    always @(posedge clk) begin
        if (rv0 && rr0) q0.push_back({cnt0, ov0, iv0, et0, len0, ovf0, runt0});
        if (rv1 && rr1) q1.push_back({cnt1, ov1, iv1, et1, len1, ovf1, runt1});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fb_new();
        fb.delete();
        for (int i = 0; i < 12; i++) fb.push_back(8'(i + 1));
    endtask

    task automatic push16(input logic [15:0] v);
        fb.push_back(v[15:8]);
        fb.push_back(v[7:0]);
    endtask

    task automatic pad(input int len);
        while (fb.size() < len) fb.push_back(8'hA5);
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input bit u1);
        int n = 0;
        in_data = d; in_sop = s; in_eop = e; v0 = !u1; v1 = u1;
        while (!(u1 ? rdy1 : rdy0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 32'(u1 ? rdy1 : rdy0), 1);
            v0 = 1'b0; v1 = 1'b0;
            return;
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic send_frame(input bit u1, input int lat);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == lat) chk("lat_pre", 32'(rv0), 0);
            send_byte(fb[i], i == 0, i == fb.size() - 1, u1);
            if (i == lat) chk("lat_post", 32'(rv0), 1);
        end
    endtask

    task automatic check_res(input string t, input bit u1, input logic [2:0] c,
                             input logic [11:0] o, input logic [11:0] i, input logic [15:0] e,
                             input logic [4:0] l, input logic f, input logic r);
        res_t g;
        repeat (2) @(negedge clk);
        if ((u1 ? q1.size() : q0.size()) == 0) begin
            chk({t, "_present"}, 32'(u1 ? q1.size() : q0.size()), 1);
            return;
        end
        g = u1 ? q1.pop_front() : q0.pop_front();
        chk({t, "_cnt"}, 32'(g.cnt), 32'(c));
        chk({t, "_outer"}, 32'(g.o), 32'(o));
        chk({t, "_inner"}, 32'(g.i), 32'(i));
        chk({t, "_etype"}, 32'(g.et), 32'(e));
        chk({t, "_len"}, 32'(g.len), 32'(l));
        chk({t, "_ovf"}, 32'(g.ovf), 32'(f));
        chk({t, "_runt"}, 32'(g.runt), 32'(r));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_valid", 32'(rv0), 0);
        chk("rst_len", 32'(len0), 14);
        chk("rst_etype", 32'(et0), 0);
        chk("rst_flags", {30'd0, ovf0, runt0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in mid-frame, then headerless bytes must be ignored.
        fb_new(); push16(16'h0800); pad(30);
        for (int i = 0; i < 10; i++) send_byte(fb[i], i == 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(rdy0), 1);
        chk("midrst_valid", 32'(rv0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 10; i < 30; i++) send_byte(fb[i], 1'b0, i == 29, 1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_nores", 32'(q0.size()), 0);

        // Untagged 64-byte IPv4; result appears the cycle after byte 13.
        fb_new(); push16(16'h0800); pad(64);
        send_frame(1'b0, 13);
        check_res("untag", 1'b0, 3'd0, 12'h0, 12'h0, 16'h0800, 5'd14, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'h81, 1'b0, i == 19, 1'b0);
        repeat (2) @(negedge clk);
        chk("idle_discard", 32'(q0.size()), 0);

        fb_new(); push16(16'h8100); push16(16'h2064); push16(16'h86DD); pad(64);
        send_frame(1'b0, -1);
        check_res("one_tag", 1'b0, 3'd1, 12'h064, 12'h0, 16'h86DD, 5'd18, 1'b0, 1'b0);

        fb_new(); push16(16'h88A8); push16(16'h0010); push16(16'h8100); push16(16'h0020);
        push16(16'h0800); pad(64);
        send_frame(1'b0, -1);
`ifdef VLAN_QINQ_EN
        check_res("qinq", 1'b0, 3'd2, 12'h010, 12'h020, 16'h0800, 5'd22, 1'b0, 1'b0);
`else
        check_res("qinq", 1'b0, 3'd0, 12'h000, 12'h000, 16'h88A8, 5'd14, 1'b0, 1'b0);
`endif

        fb_new(); push16(16'h8100); push16(16'h0001); push16(16'h8100); push16(16'h0002);
        push16(16'h8100); push16(16'h0003); push16(16'h0800); pad(64);
        send_frame(1'b0, -1);
        check_res("ovf2", 1'b0, 3'd2, 12'h001, 12'h002, 16'h8100, 5'd22, 1'b1, 1'b0);

        fb_new(); push16(16'h8100); push16(16'h0001); push16(16'h8100); push16(16'h0002);
        push16(16'h0800); pad(64);
        send_frame(1'b1, -1);
        check_res("ovf1", 1'b1, 3'd1, 12'h001, 12'h000, 16'h8100, 5'd18, 1'b1, 1'b0);

        fb_new(); push16(16'h8100);
        send_frame(1'b0, -1);
        check_res("runt14", 1'b0, 3'd0, 12'h0, 12'h0, 16'h0000, 5'd14, 1'b0, 1'b1);

        send_byte(8'h55, 1'b1, 1'b1, 1'b0);
        check_res("runt1", 1'b0, 3'd0, 12'h0, 12'h0, 16'h0000, 5'd14, 1'b0, 1'b1);

        // Abort after 8 bytes by a fresh sop.
        for (int i = 0; i < 8; i++) send_byte(8'(i), i == 0, 1'b0, 1'b0);
        fb_new(); push16(16'h8100); push16(16'h3123); push16(16'h0806); pad(40);
        send_frame(1'b0, -1);
        repeat (2) @(negedge clk);
        chk("abort_count", 32'(q0.size()), 1);
        check_res("abort", 1'b0, 3'd1, 12'h123, 12'h0, 16'h0806, 5'd18, 1'b0, 1'b0);

        // Result backpressure for 20 cycles while the frame drains.
        rr0 = 1'b0;
        fork
            begin
                fb_new(); push16(16'h0806); pad(20);
                send_frame(1'b0, -1);
                fb_new(); push16(16'h8100); push16(16'h0FFF); push16(16'h0800); pad(64);
                send_frame(1'b0, -1);
            end
            begin
                int n = 0;
                while (!rv0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_wait", 32'(rv0), 1);
                for (int k = 0; k < 20; k++) begin
                    chk("bp_ready", 32'(rdy0), 0);
                    chk("bp_valid", 32'(rv0), 1);
                    chk("bp_etype", 32'(et0), 32'h0806);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 rr0 = 1'b1;
            end
        join
        check_res("bp_a", 1'b0, 3'd0, 12'h0, 12'h0, 16'h0806, 5'd14, 1'b0, 1'b0);
        check_res("bp_b", 1'b0, 3'd1, 12'hFFF, 12'h0, 16'h0800, 5'd18, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vlan_tag_walker.md
VLAN_TAG_WALKER -- requirements
Module: vlan_tag_walker

Interface
REQ-001 The block SHALL have parameter MAX_TAGS, default 2, giving the maximum number of stacked tags resolved; legal range 1..4.
REQ-002 The block SHALL have parameter TPID_8021Q, default 16'h8100, giving the customer tag TPID.
REQ-003 The block SHALL have parameter TPID_8021AD, default 16'h88A8, giving the service tag TPID.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  byte-stream handshake; a beat transfers when both are high.
REQ-007 in_data  input  8  frame byte, first byte is destination MAC byte 0.
REQ-008 in_sop / in_eop  input  1 / 1  first and last byte of the frame.
REQ-009 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-010 vlan_count  output  3  number of tags consumed (0..MAX_TAGS).
REQ-011 outer_vid / inner_vid  output  12 / 12  VID of the first and second tag; 0 if absent.
REQ-012 resolved_ethertype  output  ethertype_t  first non-TPID ethertype.
REQ-013 l2_header_len  output  5  equals 14 + 4*vlan_count.
REQ-014 tag_overflow / runt  output  1 / 1  result error flags.

Function
REQ-015 FSM states SHALL be IDLE, MAC, ETYPE, TCI and DRAIN.
- IDLE -> MAC on an accepted in_sop beat.
- MAC -> ETYPE after 12 bytes.
- ETYPE -> TCI on 2nd byte when the value is a TPID and tags < MAX_TAGS.
- ETYPE -> DRAIN otherwise, publishing the result.
- TCI -> ETYPE after 2 bytes.
- DRAIN -> IDLE on an accepted in_eop beat.
REQ-016 A 5-bit byte counter SHALL index header bytes; it clears on every accepted in_sop.
REQ-017 TPID match SHALL be TPID_8021Q, plus TPID_8021AD when VLAN_QINQ_EN is defined.
REQ-018 The VID SHALL be {TCI byte0[3:0], TCI byte1}; tag 1 goes to outer_vid and tag 2 to inner_vid; deeper VIDs are discarded.
REQ-019 The result SHALL assert res_valid on the cycle after the beat carrying the final ethertype byte (latency 1).
REQ-020 On a TPID seen with vlan_count == MAX_TAGS, the block SHALL publish a result with tag_overflow=1 and resolved_ethertype = that TPID.
REQ-021 On in_eop accepted before resolution, the block SHALL publish runt=1 with the fields gathered so far, then return to IDLE.
REQ-022 Outputs SHALL hold stable while res_valid && !res_ready; res_valid clears the cycle after acceptance unless a new result loads that same edge.
REQ-023 in_ready SHALL equal !res_valid || res_ready; no beats are dropped.
REQ-024 An in_sop accepted in any non-IDLE state SHALL abort the current frame without a result and restart at MAC byte 0.
REQ-025 Beats accepted in IDLE without in_sop SHALL be discarded.
REQ-026 A single-byte frame (sop && eop) SHALL yield runt=1, vlan_count=0.

Reset
REQ-027 While rst_n is low:
- FSM = IDLE, counter = 0.
- res_valid = 0, vlan_count = 0, outer_vid = inner_vid = 0.
- resolved_ethertype = 0, l2_header_len = L2_HEADER_NO_VLAN (14).
- tag_overflow = runt = 0, in_ready = 1.
REQ-028 Reset mid-frame SHALL discard the frame; the first post-reset frame needs in_sop.

Configuration
REQ-029 VLAN_QINQ_EN defined: 802.1ad TPID SHALL count as a tag.
REQ-030 VLAN_QINQ_EN undefined: only TPID_8021Q SHALL count, and 0x88A8 resolves as a plain ethertype.

Structure
REQ-031 ethertype_t, ETHERTYPE_VLAN, a new ETHERTYPE_QINQ constant and the L2_HEADER_NO_VLAN / L2_HEADER_VLAN lengths SHALL live in eth_parser_pkg.
REQ-032 TPID comparison SHALL be a sub-module vlan_tpid_match; it is combinational with ports value and is_tpid, and honours VLAN_QINQ_EN.

Verification
REQ-033 Untagged frame, ethertype 0x0800, 64 bytes:
- result count=0, ethertype=0x0800, len=14, no error flags.
- FSM returns to IDLE after eop.
REQ-034 Single tag 0x8100, TCI 0x2064, then 0x86DD:
- count=1, outer_vid=0x064, ethertype=0x86DD, len=18.
REQ-035 QinQ 0x88A8 TCI 0x0010, 0x8100 TCI 0x0020, 0x0800:
- with VLAN_QINQ_EN: count=2, outer=0x010, inner=0x020, len=22.
- without VLAN_QINQ_EN: count=0, ethertype=0x88A8.
REQ-036 MAX_TAGS=1 with two 0x8100 tags:
- tag_overflow=1, count=1, ethertype=0x8100.
REQ-037 Runt and restart cases:
- Frame ending after byte 13 (0x81,0x00): runt=1, count=0.
- New sop at byte 8 of a frame: no result for the aborted frame; the following frame resolves correctly.
REQ-038 res_ready held low 20 cycles during drain:
- in_ready=0 for those cycles, outputs stable.
- No beat is lost; the next frame's result is correct.
